// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared constants for the router-side NIC link endpoint.
// Revision: 1.0
`default_nettype none

package cardinal_pkg;
    localparam int DATA_W = 64;
    localparam int VC_BIT = DATA_W - 1;
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // Processor-side NIC register map, kept here so both link ends agree.
    localparam logic [1:0] NIC_ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STATUS = 2'b11;
endpackage

`default_nettype wire

// File: rtl/cardinal_vc_fifo.sv
// cardinal_vc_fifo: single virtual-channel FIFO with wrap-bit pointers.
// Revision: 1.0
`default_nettype none

module cardinal_vc_fifo
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = (AW > 0) ? AW : 1;

    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [IW-1:0]     w_wr_idx;
    logic [IW-1:0]     w_rd_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    generate
        if (DEPTH == 1) begin : g_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end else begin : g_multi
            assign w_wr_idx = r_wr[IW-1:0];
            assign w_rd_idx = r_rd[IW-1:0];
        end
    endgenerate

    // Full when only the wrap bit differs between the pointers.
    assign o_full    = ((r_wr ^ r_rd) == PW'(DEPTH));
    assign o_empty   = (r_wr == r_rd);
    assign o_head    = r_mem[w_rd_idx];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[w_wr_idx] <= i_din;
    end
endmodule

`default_nettype wire

// File: rtl/cardinal_nic_port.sv
// cardinal_nic_port: router-side NIC link endpoint with even/odd VC buffers per direction.
// Revision: 1.0
`default_nettype none

module cardinal_nic_port
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              net_polarity,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_do,
    output logic              net_si,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_di,
    output logic              ing_so,
    input  logic              ing_ro,
    output logic [DATA_W-1:0] ing_do,
    input  logic              egr_si,
    output logic [1:0]        egr_ri,
    input  logic [DATA_W-1:0] egr_di
);
    localparam int VCB = DATA_W - 1;

    logic              r_pol;
    logic              r_rr;
    logic              r_si;
    logic [DATA_W-1:0] r_di;

    logic [1:0]        w_ing_push, w_ing_pop, w_ing_full, w_ing_empty;
    logic [1:0]        w_egr_push, w_egr_pop, w_egr_full, w_egr_empty;
    logic [DATA_W-1:0] w_ing_head [2];
    logic [DATA_W-1:0] w_egr_head [2];
    logic              w_sel;
    logic              w_egr_send;

    generate
        for (genvar v = 0; v < 2; v++) begin : g_vc
            // Arrivals are pushed unconditionally; the FIFO itself drops on full.
            assign w_ing_push[v] = net_so & (net_do[VCB] == 1'(v));
            assign w_ing_pop[v]  = ing_so & ing_ro & (w_sel == 1'(v));
            assign w_egr_push[v] = egr_si & (egr_di[VCB] == 1'(v)) & ~w_egr_full[v];
            assign w_egr_pop[v]  = w_egr_send & (r_pol == 1'(v));

            cardinal_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ing (
                .clk     (clk),
                .rst_n   (reset),
                .i_push  (w_ing_push[v]),
                .i_din   (net_do),
                .i_pop   (w_ing_pop[v]),
                .o_full  (w_ing_full[v]),
                .o_empty (w_ing_empty[v]),
                .o_head  (w_ing_head[v])
            );

            cardinal_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_egr (
                .clk     (clk),
                .rst_n   (reset),
                .i_push  (w_egr_push[v]),
                .i_din   (egr_di),
                .i_pop   (w_egr_pop[v]),
                .o_full  (w_egr_full[v]),
                .o_empty (w_egr_empty[v]),
                .o_head  (w_egr_head[v])
            );
        end
    endgenerate

    // With both VCs pending, serve the one not served last.
    always_comb begin
        w_sel = VC_EVEN;
        if (!w_ing_empty[0] && !w_ing_empty[1]) begin
            w_sel = ~r_rr;
        end else if (!w_ing_empty[1]) begin
            w_sel = VC_ODD;
        end
    end

    assign ing_so       = ~(w_ing_empty[0] & w_ing_empty[1]);
    assign ing_do       = w_ing_head[w_sel];
    assign net_ro       = ~w_ing_full[r_pol];
    assign egr_ri       = ~w_egr_full;
    assign net_polarity = r_pol;
    assign net_si       = r_si;
    assign net_di       = r_di;

    // The ~r_si term leaves a gap cycle so the NIC's net_ri can drop after an accept.
    assign w_egr_send = net_ri & ~r_si & ~w_egr_empty[r_pol];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pol <= 1'b0;
            r_rr  <= 1'b0;
            r_si  <= 1'b0;
            r_di  <= '0;
        end else begin
            r_pol <= ~r_pol;
            if (ing_so && ing_ro) r_rr <= w_sel;
            if (w_egr_send) begin
                r_si <= 1'b1;
                r_di <= w_egr_head[r_pol];
            end else begin
                r_si <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cardinal_nic_port.sv
// tb_cardinal_nic_port: scoreboard bench for the router-side NIC link endpoint.
// Revision: 1.0
`default_nettype none

module tb_cardinal_nic_port;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              net_polarity, net_so, net_ro, net_si, net_ri;
    logic [DATA_W-1:0] net_do, net_di, ing_do, egr_di;
    logic              ing_so, ing_ro, egr_si;
    logic [1:0]        egr_ri;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [63:0]       q_ing[$];
    logic [63:0]       q_e0[$];
    logic [63:0]       q_e1[$];
    int                cnt[2];
    logic              prev_si = 1'b0;
    logic              exp_pol;

    cardinal_nic_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .ing_so       (ing_so),
        .ing_ro       (ing_ro),
        .ing_do       (ing_do),
        .egr_si       (egr_si),
        .egr_ri       (egr_ri),
        .egr_di       (egr_di)
    );

    always #5 clk = ~clk;

    // Reference polarity: 0 in reset, toggling every cycle afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_pol <= 1'b0;
        else        exp_pol <= ~exp_pol;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected, expected event", name);
    endtask

    // Monitor: compares every ingress pop and every egress delivery against the queues.
    always @(negedge clk) begin
        logic [63:0] e;
        logic        vc;
        if (rst_n) begin
            if (net_so) begin
                check("ing_push_room", 64'(cnt[int'(net_do[63])] < DEPTH), 64'd1);
                cnt[int'(net_do[63])]++;
            end
            if (ing_so && ing_ro) begin
                if (q_ing.size() == 0) begin
                    fail_now("ing_unexpected");
                end else begin
                    e = q_ing.pop_front();
                    check("ing_data", ing_do, e);
                end
                cnt[int'(ing_do[63])]--;
            end
            if (net_si) begin
                check("egr_gap", 64'(prev_si), 64'd0);
                vc = ~exp_pol;
                if (vc ? (q_e1.size() == 0) : (q_e0.size() == 0)) begin
                    fail_now("egr_unexpected");
                end else begin
                    e = vc ? q_e1.pop_front() : q_e0.pop_front();
                    check("egr_data", net_di, e);
                end
            end
            prev_si = net_si;
        end else begin
            prev_si = 1'b0;
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic nic_send(input logic [63:0] pkt);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (net_polarity == pkt[63] && net_ro) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail_now("nic_send_timeout");
        end else begin
            drive_edge();
            net_so = 1'b1;
            net_do = pkt;
            drive_edge();
            net_so = 1'b0;
        end
    endtask

    task automatic egr_push(input logic [63:0] pkt);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (egr_ri[pkt[63]]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail_now("egr_push_timeout");
        end else begin
            drive_edge();
            egr_si = 1'b1;
            egr_di = pkt;
            if (pkt[63]) q_e1.push_back(pkt);
            else         q_e0.push_back(pkt);
            drive_edge();
            egr_si = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q_ing.size() == 0 && q_e0.size() == 0 && q_e1.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic check_reset_values();
        check("rst_polarity", 64'(net_polarity), 64'd0);
        check("rst_net_ro",   64'(net_ro),       64'd1);
        check("rst_egr_ri",   64'(egr_ri),       64'd3);
        check("rst_net_si",   64'(net_si),       64'd0);
        check("rst_net_di",   net_di,            64'd0);
        check("rst_ing_so",   64'(ing_so),       64'd0);
    endtask

    initial begin
        logic seen;
        net_so = 1'b0; net_do = '0; ing_ro = 1'b0;
        egr_si = 1'b0; egr_di = '0; net_ri = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        repeat (3) @(negedge clk);
        check_reset_values();

        // Polarity after release: 1,0,1,0 at successive negedges.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("polarity_seq", 64'(net_polarity), (i % 2 == 0) ? 64'd1 : 64'd0);
        end

        // Single even ingress packet.
        drive_edge();
        ing_ro = 1'b1;
        q_ing.push_back(64'h0000_0000_0000_00A5);
        nic_send(64'h0000_0000_0000_00A5);
        @(negedge clk);
        check("ing_so_after_send", 64'(ing_so), 64'd1);
        wait_drain("drain_a5");

        // Fill the even VC with core stalled: net_ro tracks polarity.
        drive_edge();
        ing_ro = 1'b0;
        q_ing.push_back(64'h0000_0000_0000_0101);
        q_ing.push_back(64'h0000_0000_0000_0202);
        nic_send(64'h0000_0000_0000_0101);
        nic_send(64'h0000_0000_0000_0202);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("net_ro_full_even", 64'(net_ro), 64'(exp_pol));
        end
        drive_edge();
        ing_ro = 1'b1;
        wait_drain("drain_even_fill");

        // Round robin: last served was even, so odd goes first, then alternate.
        drive_edge();
        ing_ro = 1'b0;
        nic_send(64'h0000_0000_0000_0E01);
        nic_send(64'h8000_0000_0000_0D01);
        nic_send(64'h0000_0000_0000_0E02);
        nic_send(64'h8000_0000_0000_0D02);
        q_ing.push_back(64'h8000_0000_0000_0D01);
        q_ing.push_back(64'h0000_0000_0000_0E01);
        q_ing.push_back(64'h8000_0000_0000_0D02);
        q_ing.push_back(64'h0000_0000_0000_0E02);
        drive_edge();
        ing_ro = 1'b1;
        wait_drain("drain_rr");

        // Egress odd packet, then a second one held back by net_ri=0.
        drive_edge();
        net_ri = 1'b1;
        egr_push(64'h8000_0000_0000_0011);
        wait_drain("drain_egr_odd");
        drive_edge();
        net_ri = 1'b0;
        egr_push(64'h8000_0000_0000_0022);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= net_si;
        end
        check("egr_hold_no_ri", 64'(seen), 64'd0);
        drive_edge();
        net_ri = 1'b1;
        wait_drain("drain_egr_held");

        // Both VCs queued with net_ri held high: one-cycle gap between sends.
        drive_edge();
        net_ri = 1'b0;
        egr_push(64'h0000_0000_0000_0033);
        egr_push(64'h0000_0000_0000_0055);
        egr_push(64'h8000_0000_0000_0044);
        egr_push(64'h8000_0000_0000_0066);
        drive_edge();
        net_ri = 1'b1;
        wait_drain("drain_egr_b2b");

        // Reset mid-traffic with packets buffered in both directions.
        drive_edge();
        ing_ro = 1'b0;
        net_ri = 1'b0;
        nic_send(64'h0000_0000_0000_0077);
        egr_push(64'h8000_0000_0000_0088);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q_ing.delete(); q_e0.delete(); q_e1.delete();
        cnt[0] = 0; cnt[1] = 0;
        ing_ro = 1'b1;
        net_ri = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= ing_so | net_si;
        end
        check("post_reset_no_stale", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
